// File: rtl/mpu_eth_pkg.sv
// mpu_eth_pkg: frame geometry, default addressing and FSM encoding shared by
// the transmit framer and the receive parser.
package mpu_eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_MIN_BYTES = 60;
  localparam int MIN_BEATS     = ETH_MIN_BYTES / 4;
  // Largest payload (words) whose frame still needs zero padding to 60 bytes.
  localparam int SHORT_N_MAX   = (ETH_MIN_BYTES - ETH_HDR_BYTES) / 4;

  localparam logic [47:0] DEF_SRC_MAC   = 48'h0002_4D50_5500;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

  // Framer FSM encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_BODY = 3'd2;
  localparam state_t ST_TAIL = 3'd3;
  localparam state_t ST_PAD  = 3'd4;

endpackage

// File: rtl/mpu_eth_tx_framer_if.sv
// mpu_eth_tx_framer_if: payload input stream and Avalon-ST output stream of
// the framer. master = framer side, slave = payload source / MAC side.
interface mpu_eth_tx_framer_if;

  logic [31:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;

  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_empty;
  logic        tx_error;

  modport master (
    input  pl_data, pl_valid, tx_ready,
    output pl_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_empty, tx_error
  );

  modport slave (
    output pl_data, pl_valid, tx_ready,
    input  pl_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_empty, tx_error
  );

endinterface

// File: rtl/mpu_eth_shift16.sv
// mpu_eth_shift16: 16-bit carry register that realigns payload words by half
// a word. dout = {carry, din[31:16]}; carry takes din[15:0] on advance.
module mpu_eth_shift16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        advance,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [15:0] carry_q;

  // Carry update: flush wins, then preload (EtherType), then word advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= '0;
    end else if (flush) begin
      carry_q <= '0;
    end else if (load) begin
      carry_q <= load_val;
    end else if (advance) begin
      carry_q <= din[15:0];
    end
  end

  assign dout = {carry_q, din[31:16]};

endmodule

// File: rtl/mpu_eth_tx_framer.sv
// mpu_eth_tx_framer: prepends the Ethernet header to MPU payload words,
// realigns the payload by 16 bits, pads short frames to 60 bytes and streams
// the result to the MAC TX FIFO (CRC appended by the MAC).
//
// state | meaning
// IDLE  | waiting for an accepted start
// HDR   | beats b0..b2: destination and source MAC
// BODY  | b3 .. beat consuming the last payload word (waits on pl_valid)
// TAIL  | single eop beat carrying the last half word, tx_empty=2
// PAD   | carry half word then zeros up to beat 14, eop on beat 14
module mpu_eth_tx_framer
  import mpu_eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
  parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
  parameter int          MAX_WORDS = 368,
  parameter int          LEN_W     = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [47:0]          dst_mac,
  input  logic [LEN_W-1:0]     len_words,
  output logic                 busy,
  output logic                 len_err,
  mpu_eth_tx_framer_if.master  bus,
  output logic                 ff_tx_crc_fwd,
  input  logic                 ff_tx_a_full,
  input  logic                 ff_tx_uflow,
  output logic [15:0]          frames_sent,
  output logic [7:0]           uflow_cnt
);

  localparam logic [LEN_W-1:0] MAX_N     = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] SHORT_N   = LEN_W'(SHORT_N_MAX);
  localparam logic [LEN_W-1:0] HDR_FIRST = LEN_W'(2);
  // Down-count start for PAD so that beat 14 lands on terminal count.
  localparam logic [LEN_W-1:0] PAD_BASE  = LEN_W'(MIN_BEATS - 4);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] n_q;
  logic [47:0]      dst_q;
  logic             len_ok;
  logic             start_ok;
  logic             beat_ok;
  logic             eop_ok;
  logic             shift_adv;
  logic [31:0]      shift_din;
  logic [31:0]      shift_dout;

  // Reset: asserts asynchronously, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign len_ok    = (len_words != '0) && (len_words <= MAX_N);
  assign start_ok  = (state_q == ST_IDLE) && start && len_ok && !ff_tx_a_full;
  assign beat_ok   = bus.tx_valid && bus.tx_ready;
  assign eop_ok    = beat_ok && bus.tx_eop;
  assign shift_adv = beat_ok && (state_q != ST_IDLE) && (state_q != ST_HDR);

  assign busy          = (state_q != ST_IDLE);
  assign ff_tx_crc_fwd = 1'b0;
  assign bus.tx_error  = 1'b0;

  // Carry preloads with the EtherType so b3 falls out of the same realign path.
  mpu_eth_shift16 u_shift (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .load     (start_ok),
    .load_val (ETHERTYPE),
    .advance  (shift_adv),
    .flush    (eop_ok),
    .din      (shift_din),
    .dout     (shift_dout)
  );

  // Output beat decode; payload only feeds the realigner in BODY.
  always_comb begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.tx_sop   = 1'b0;
    bus.tx_eop   = 1'b0;
    bus.tx_empty = 2'd0;
    bus.pl_ready = 1'b0;
    shift_din    = '0;
    case (state_q)
      ST_HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_sop   = (cnt_q == HDR_FIRST);
        if (cnt_q == HDR_FIRST)          bus.tx_data = dst_q[47:16];
        else if (cnt_q == LEN_W'(1))     bus.tx_data = {dst_q[15:0], SRC_MAC[47:32]};
        else                             bus.tx_data = SRC_MAC[31:0];
      end
      ST_BODY: begin
        shift_din    = bus.pl_data;
        bus.tx_valid = bus.pl_valid;
        bus.tx_data  = shift_dout;
        bus.pl_ready = bus.tx_ready && bus.pl_valid;
      end
      ST_TAIL: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = shift_dout;
        bus.tx_eop   = 1'b1;
        bus.tx_empty = 2'd2;
      end
      ST_PAD: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = shift_dout;
        bus.tx_eop   = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  // Frame sequencing: cnt_q counts down the beats left in the current state.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      dst_q   <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= (state_q == ST_IDLE) && start && !len_ok;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_HDR;
            cnt_q   <= HDR_FIRST;
            n_q     <= len_words;
            dst_q   <= dst_mac;
          end
        end
        ST_HDR: begin
          if (beat_ok) begin
            if (cnt_q == '0) begin
              state_q <= ST_BODY;
              cnt_q   <= n_q - LEN_W'(1);
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        ST_BODY: begin
          if (beat_ok) begin
            if (cnt_q == '0) begin
              if (n_q > SHORT_N) begin
                state_q <= ST_TAIL;
              end else begin
                state_q <= ST_PAD;
                cnt_q   <= PAD_BASE - n_q;
              end
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        ST_TAIL: begin
          if (beat_ok) state_q <= ST_IDLE;
        end
        ST_PAD: begin
          if (beat_ok) begin
            if (cnt_q == '0) state_q <= ST_IDLE;
            else             cnt_q   <= cnt_q - LEN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status counters: frames wrap, underflows saturate; both may fire together.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frames_sent <= '0;
      uflow_cnt   <= '0;
    end else begin
      if (eop_ok) frames_sent <= frames_sent + 16'd1;
      if (ff_tx_uflow && (uflow_cnt != 8'hFF)) uflow_cnt <= uflow_cnt + 8'd1;
    end
  end

endmodule

// File: doc/mpu_eth_tx_framer.md
Name: mpu_eth_tx_framer

Overview:
- Transmit-side framer between the MPU result path and the TSE MAC transmit FIFO.
- Takes 32-bit MPU payload words and prepends the Ethernet header: destination MAC, fixed source MAC, EtherType.
- Shifts the payload by 16 bits to keep big-endian byte order, and zero-pads short frames to 60 bytes.
- Streams the frame as 32-bit Avalon-ST (readyLatency 0) and leaves CRC insertion to the MAC (ff_tx_crc_fwd tied low).

Parameters:
- SRC_MAC, 48'h0002_4D50_5500, source MAC placed in header bytes 6..11
- ETHERTYPE, 16'h88B5, EtherType in header bytes 12..13
- MAX_WORDS, 368, maximum payload words per frame (1472 bytes)
- LEN_W, 9, width of len_words

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- start  in  1  one-cycle request to send a frame; sampled only in IDLE
- dst_mac  in  48  destination MAC, captured on accepted start
- len_words  in  LEN_W  payload length N in words, captured on accepted start
- busy  out  1  high from accepted start until the eop beat is accepted
- len_err  out  1  one-cycle pulse when start is rejected because N==0 or N>MAX_WORDS
- pl_data  in  32  payload word, byte0 in [31:24]
- pl_valid  in  1  payload word valid
- pl_ready  out  1  payload word consumed this cycle
- tx_data  out  32  Avalon-ST data to the MAC, first byte in [31:24]
- tx_valid  out  1  beat valid
- tx_ready  in  1  MAC accepts beat
- tx_sop  out  1  first beat of frame
- tx_eop  out  1  last beat of frame
- tx_empty  out  2  invalid bytes in the eop beat
- tx_error  out  1  always 0 (reserved)
- ff_tx_crc_fwd  out  1  constant 0; the MAC appends the CRC
- ff_tx_a_full  in  1  MAC TX FIFO almost full
- ff_tx_uflow  in  1  MAC TX FIFO underflow pulse
- frames_sent  out  16  wrapping count of completed frames
- uflow_cnt  out  8  saturating count of ff_tx_uflow pulses

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0, FSM in IDLE, counters 0.
  - Reset mid-frame abandons the frame; no eop is issued.
- Start acceptance:
  - start is accepted in IDLE only when ff_tx_a_full==0 and 1<=N<=MAX_WORDS.
  - If N is out of range, len_err pulses the next cycle and the block stays IDLE.
  - start while busy is ignored.
- Frame layout (beats b0..):
  - b0 = dst[47:16]; b1 = {dst[15:0], SRC[47:32]}; b2 = SRC[31:0]; b3 = {ETHERTYPE, p0[31:16]}.
  - bk (k>=4) = {p(k-4)[15:0], p(k-3)[31:16]}. Missing payload words (index >= N) read as 0.
  - A 16-bit carry register holds the low half of the previous payload word.
- Beat count and tx_empty:
  - N>=12: N+4 beats, last beat = {pN-1[15:0], 16'h0}, tx_empty=2.
  - N<=11: 15 beats (60 bytes), zero pad, tx_empty=0.
  - tx_empty is 0 on every non-eop beat.
- FSM states and transitions:
  - IDLE -> HDR on accepted start.
  - HDR (b0..b2) -> BODY.
  - BODY (b3 .. the beat consuming pN-1): then TAIL if N>=12, else PAD.
  - TAIL: one beat, eop.
  - PAD: zeros until beat 14, eop on beat 14.
  - eop acceptance returns to IDLE the next cycle.
- Handshake:
  - tx_valid/tx_data/sop/eop/empty are held stable while tx_valid && !tx_ready.
  - pl_ready is asserted only in BODY, in the cycle the beat that needs pl_data is presented and accepted, i.e. pl_ready = tx_ready && pl_valid.
  - If pl_valid==0 in BODY, tx_valid drops (bubble) and the FSM waits; no data is lost.
  - HDR, TAIL and PAD never assert pl_ready.
- Counters:
  - frames_sent increments on eop acceptance and wraps at 16'hFFFF -> 0.
  - uflow_cnt saturates at 255.
  - An ff_tx_uflow pulse and an eop in the same cycle both take effect.
- ff_tx_a_full is checked only at start; mid-frame, tx_ready alone is authoritative.
- Latency: the first tx_valid appears one cycle after the accepted start.

Decomposition:
- Package mpu_eth_pkg holds:
  - FSM state enum
  - ETH_HDR_BYTES=14
  - ETH_MIN_BYTES=60
  - MIN_BEATS=15
  - SHORT_N_MAX=11
  - default SRC_MAC and ETHERTYPE constants, shared with the receive parser.
- One sub-module, mpu_eth_shift16: the 16-bit carry/realign register with load/advance/flush controls.
- FSM and counters stay in the top.

Test Plan:
- N=12, payload 0x00010203,0x04050607,..., dst=AABBCCDDEEFF, tx_ready=1:
  - 16 beats; b0=AABBCCDD, b3=88B50001.
  - b15 = {last word [15:0], 0000}, tx_empty=2, eop; frames_sent=1.
- N=1, pl=0xDEADBEEF:
  - 15 beats; b3=88B5DEAD, b4=BEEF0000, b5..b14=0.
  - eop on b14 with tx_empty=0; exactly one pl_ready pulse.
- N=40 with tx_ready toggled by a random 50% pattern and pl_valid gaps:
  - Outputs stable while stalled, no duplicated or dropped words.
  - Byte stream equals header||payload.
- start with N=0, then N=369:
  - len_err pulses twice, busy stays 0, no tx_valid.
- start while ff_tx_a_full=1:
  - Ignored until ff_tx_a_full drops and start is re-pulsed.
  - start pulsed again mid-frame: no effect on the frame.
- reset_n low at beat 6 of a 20-word frame:
  - All outputs 0 immediately; next frame (N=12) transmits correctly.
  - 300 ff_tx_uflow pulses -> uflow_cnt=255.
